mash_dsm_param: RTL and testbench
=================================

MASH_DSM_PARAM -- requirements
Module: mash_dsm_param

Interface
REQ-001 The block SHALL have parameter ACC_W, default 16, meaning accumulator and fractional input width (8..32).
REQ-002 The block SHALL have parameter INT_W, default 4, meaning integer input and divide output width (3..8).
REQ-003 The block SHALL have parameter ORDER, default 3, meaning number of active cascaded stages (1, 2 or 3).
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit, meaning modulator advance enable.
REQ-007 The block SHALL have port clr, input, 1 bit, meaning synchronous clear of the modulator state.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit, meaning a new divide ratio is offered.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit, meaning the block can accept a divide ratio.
REQ-010 The block SHALL have port cfg_int, input, INT_W bits, meaning the unsigned integer part.
REQ-011 The block SHALL have port cfg_frac, input, ACC_W bits, meaning the unsigned fractional part.
REQ-012 The block SHALL have port out, output, INT_W bits, meaning the registered instantaneous divide value.
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning out was updated this cycle.
REQ-014 The block SHALL have port sat, output, 1 bit, meaning out was clamped this cycle.

Function
REQ-015 The block SHALL hold an active ratio (act_int, act_frac) and a one-entry shadow (shd_int, shd_frac, pend).
REQ-016 The block SHALL drive cfg_ready = !pend, and SHALL load the shadow and set pend when cfg_valid && cfg_ready.
REQ-017 When pend=1 and en=1, the block SHALL copy the shadow into the active ratio and clear pend at that edge; the new ratio first drives stage 1 on the following enabled cycle.
REQ-018 When pend=1 and en=0, the shadow SHALL be held, and cfg_valid SHALL be ignored.
REQ-019 On an enabled cycle, stage k SHALL compute the (ACC_W+1)-bit sum acc_k + x_k, register the low ACC_W bits into acc_k, and register bit ACC_W into c_k; x_1 = act_frac, x_2 = acc_1, x_3 = acc_2 (pre-update register values).
REQ-020 Stages above ORDER SHALL be held at zero.
REQ-021 The block SHALL keep histories c2_z1, c3_z1 and c3_z2, updated only on enabled cycles.
REQ-022 The correction SHALL be the signed value f = c1 + (c2 - c2_z1) + (c3 - 2*c3_z1 + c3_z2), giving the range -3..+4 for ORDER 3, -1..+2 for ORDER 2 and 0..1 for ORDER 1.
REQ-023 On each enabled cycle, out SHALL register act_int + f, computed signed at INT_W+2 bits, clamped to 0..2^INT_W-1; sat SHALL be 1 exactly when clamping occurred, else 0.
REQ-024 out_valid SHALL equal en delayed by one cycle; when en=0, out and sat SHALL hold.
REQ-025 clr=1 SHALL zero the accumulators, carries, histories, out, sat and out_valid at the next edge without affecting the active ratio, shadow or pend; clr SHALL take priority over en.
REQ-026 The long-run mean of out over 2^ACC_W enabled cycles with a constant ratio SHALL equal act_int + act_frac/2^ACC_W exactly, provided no clamping occurs.

Reset
REQ-027 With rst_n=0, all registers SHALL be zero: out=0, sat=0, out_valid=0, pend=0, cfg_ready=1, active ratio=0.
REQ-028 Reset assertion mid-operation SHALL discard any pending shadow immediately.

Verification
REQ-029 Reset, then load cfg 7/0x0000 with en=1: out=7 on every cycle, sat=0.
REQ-030 Load cfg 7/0x8000, ORDER=3, run 65536 enabled cycles: sum of out = 7*65536+32768, out in 4..11.
REQ-031 Set cfg_valid with en=0: accepted once, then cfg_ready=0 until the first en=1 edge; a second offer is not accepted during that time.
REQ-032 Load cfg 0/0xFFFF, ORDER=3: sat=1 on cycles where f<0, and out never below 0.
REQ-033 Run mid-sequence, toggle en=0 for 5 cycles: out, accumulators and out_valid=0 frozen; the resumed sequence matches a gapless golden model.
REQ-034 Assert clr mid-run, then assert rst_n=0 mid-run: state zeroed as specified, active ratio kept on clr and lost on reset.

Source files
------------

// File: rtl/mash_dsm_param.sv
// MASH 1-1-1 delta-sigma modulator for fractional-N divide ratios.
// Holds an active ratio plus a one-entry shadow loaded through a valid/ready
// handshake. Up to three cascaded first-order accumulators produce carries that
// are noise-shaped into a signed correction added to the integer part. The
// result is clamped to the output range and registered.
module mash_dsm_param #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned INT_W = 4,
    parameter int unsigned ORDER = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [INT_W-1:0] cfg_int,
    input  logic [ACC_W-1:0] cfg_frac,
    output logic [INT_W-1:0] out,
    output logic             out_valid,
    output logic             sat
);

    // Two guard bits cover the correction range -3..+4 on top of act_int.
    localparam int unsigned SW = INT_W + 2;

    // Ratio registers
    logic [INT_W-1:0] act_int_q, act_int_d;
    logic [ACC_W-1:0] act_frac_q, act_frac_d;
    logic [INT_W-1:0] shd_int_q, shd_int_d;
    logic [ACC_W-1:0] shd_frac_q, shd_frac_d;
    logic             pend_q, pend_d;

    // Accumulator stages, carries and carry histories
    logic [ACC_W-1:0] acc1_q, acc1_d;
    logic [ACC_W-1:0] acc2_q, acc2_d;
    logic [ACC_W-1:0] acc3_q, acc3_d;
    logic             c1_q, c1_d;
    logic             c2_q, c2_d;
    logic             c3_q, c3_d;
    logic             c2_z1_q, c2_z1_d;
    logic             c3_z1_q, c3_z1_d;
    logic             c3_z2_q, c3_z2_d;

    // Full-width stage sums; the top bit is the stage carry
    logic [ACC_W:0]   sum1;
    logic [ACC_W:0]   sum2;
    logic [ACC_W:0]   sum3;

    // Output registers
    logic [INT_W-1:0] out_q, out_d;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;

    // Signed correction arithmetic
    logic signed [SW-1:0] c1_s;
    logic signed [SW-1:0] c2_s;
    logic signed [SW-1:0] c2_z1_s;
    logic signed [SW-1:0] c3_s;
    logic signed [SW-1:0] c3_z1_x2_s;
    logic signed [SW-1:0] c3_z2_s;
    logic signed [SW-1:0] corr;
    logic signed [SW-1:0] int_s;
    logic signed [SW-1:0] max_s;
    logic signed [SW-1:0] raw;

    assign cfg_ready = !pend_q;
    assign out       = out_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;

    // Shadow handshake and shadow-to-active transfer on the next enabled cycle.
    // clr leaves the ratio path untouched.
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;
        if (pend_q) begin
            if (en) begin
                act_int_d  = shd_int_q;
                act_frac_d = shd_frac_q;
                pend_d     = 1'b0;
            end
        end else if (cfg_valid) begin
            shd_int_d  = cfg_int;
            shd_frac_d = cfg_frac;
            pend_d     = 1'b1;
        end
    end

    // Ratio state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int_q  <= '0;
            act_frac_q <= '0;
            shd_int_q  <= '0;
            shd_frac_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
        end
    end

    // Cascaded accumulator next state; each stage integrates the previous
    // stage's pre-update residue, and unused stages stay at zero.
    always_comb begin
        sum1    = {1'b0, acc1_q} + {1'b0, act_frac_q};
        sum2    = {1'b0, acc2_q} + {1'b0, acc1_q};
        sum3    = {1'b0, acc3_q} + {1'b0, acc2_q};
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        acc3_d  = acc3_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        c2_z1_d = c2_z1_q;
        c3_z1_d = c3_z1_q;
        c3_z2_d = c3_z2_q;
        if (clr) begin
            acc1_d  = '0;
            acc2_d  = '0;
            acc3_d  = '0;
            c1_d    = 1'b0;
            c2_d    = 1'b0;
            c3_d    = 1'b0;
            c2_z1_d = 1'b0;
            c3_z1_d = 1'b0;
            c3_z2_d = 1'b0;
        end else if (en) begin
            acc1_d = sum1[ACC_W-1:0];
            c1_d   = sum1[ACC_W];
            if (ORDER >= 2) begin
                acc2_d = sum2[ACC_W-1:0];
                c2_d   = sum2[ACC_W];
            end
            if (ORDER >= 3) begin
                acc3_d = sum3[ACC_W-1:0];
                c3_d   = sum3[ACC_W];
            end
            c2_z1_d = c2_q;
            c3_z1_d = c3_q;
            c3_z2_d = c3_z1_q;
        end
    end

    // Accumulator state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1_q  <= '0;
            acc2_q  <= '0;
            acc3_q  <= '0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            c3_q    <= 1'b0;
            c2_z1_q <= 1'b0;
            c3_z1_q <= 1'b0;
            c3_z2_q <= 1'b0;
        end else begin
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            acc3_q  <= acc3_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            c2_z1_q <= c2_z1_d;
            c3_z1_q <= c3_z1_d;
            c3_z2_q <= c3_z2_d;
        end
    end

    // Noise-shaped correction, added to the integer part and clamped to range
    always_comb begin
        c1_s       = {{(SW-1){1'b0}}, c1_q};
        c2_s       = {{(SW-1){1'b0}}, c2_q};
        c2_z1_s    = {{(SW-1){1'b0}}, c2_z1_q};
        c3_s       = {{(SW-1){1'b0}}, c3_q};
        c3_z1_x2_s = {{(SW-2){1'b0}}, c3_z1_q, 1'b0};
        c3_z2_s    = {{(SW-1){1'b0}}, c3_z2_q};
        corr       = c1_s + (c2_s - c2_z1_s) + (c3_s - c3_z1_x2_s + c3_z2_s);
        int_s      = $signed({2'b00, act_int_q});
        max_s      = $signed({2'b00, {INT_W{1'b1}}});
        raw        = int_s + corr;

        out_d       = out_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        if (clr) begin
            out_d = '0;
            sat_d = 1'b0;
        end else if (en) begin
            out_valid_d = 1'b1;
            if (raw < 0) begin
                out_d = '0;
                sat_d = 1'b1;
            end else if (raw > max_s) begin
                out_d = {INT_W{1'b1}};
                sat_d = 1'b1;
            end else begin
                out_d = raw[INT_W-1:0];
                sat_d = 1'b0;
            end
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mash_dsm_param.sv
// Self-checking bench for mash_dsm_param (default parameters, ORDER=3).
module tb_mash_dsm_param;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_int;
    logic [15:0] cfg_frac;
    logic [3:0]  out;
    logic        out_valid;
    logic        sat;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_acc1, m_acc2, m_acc3, m_c1, m_c2, m_c3, m_h2, m_h31, m_h32;
    int m_act_int, m_act_frac, m_shd_int, m_shd_frac, m_pend;
    int m_out, m_sat, m_ov;

    typedef struct {
        logic [3:0]  ci;
        logic [15:0] cf;
        int          exp_sum;
        int          lo;
        int          hi;
    } vec_t;

    vec_t vecs [5];

    mash_dsm_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_int   (cfg_int),
        .cfg_frac  (cfg_frac),
        .out       (out),
        .out_valid (out_valid),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
        m_c1 = 0; m_c2 = 0; m_c3 = 0; m_h2 = 0; m_h31 = 0; m_h32 = 0;
        m_act_int = 0; m_act_frac = 0; m_shd_int = 0; m_shd_frac = 0; m_pend = 0;
        m_out = 0; m_sat = 0; m_ov = 0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic cycle();
        int f, v, n1, n2, n3;
        if (clr) begin
            m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
            m_c1 = 0; m_c2 = 0; m_c3 = 0; m_h2 = 0; m_h31 = 0; m_h32 = 0;
            m_out = 0; m_sat = 0; m_ov = 0;
        end else if (en) begin
            f = m_c1 + m_c2 - m_h2 + m_c3 - 2 * m_h31 + m_h32;
            v = m_act_int + f;
            if (v < 0) begin
                m_out = 0; m_sat = 1;
            end else if (v > 15) begin
                m_out = 15; m_sat = 1;
            end else begin
                m_out = v; m_sat = 0;
            end
            n1 = m_acc1 + m_act_frac;
            n2 = m_acc2 + m_acc1;
            n3 = m_acc3 + m_acc2;
            m_h32 = m_h31;
            m_h31 = m_c3;
            m_h2  = m_c2;
            m_c1 = n1 / 65536; m_acc1 = n1 % 65536;
            m_c2 = n2 / 65536; m_acc2 = n2 % 65536;
            m_c3 = n3 / 65536; m_acc3 = n3 % 65536;
            m_ov = 1;
        end else begin
            m_ov = 0;
        end
        if (m_pend != 0) begin
            if (en) begin
                m_act_int = m_shd_int; m_act_frac = m_shd_frac; m_pend = 0;
            end
        end else if (cfg_valid) begin
            m_shd_int = int'(cfg_int); m_shd_frac = int'(cfg_frac); m_pend = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk();
        cycle();
        chk("out", int'(out), m_out);
        chk("sat", int'(sat), m_sat);
        chk("out_valid", int'(out_valid), m_ov);
    endtask

    // Offer a ratio, commit it with one enabled cycle, then clear the modulator.
    task automatic load_ratio(input logic [3:0] ci, input logic [15:0] cf);
        cfg_int = ci; cfg_frac = cf; cfg_valid = 1'b1; en = 1'b0; clr = 1'b0;
        cycle();
        cfg_valid = 1'b0; en = 1'b1;
        cycle();
        en = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0; en = 1'b1;
    endtask

    initial begin
        int sum, mn, mx, satc;
        vecs[0] = '{4'd7,  16'h0000, 7168, 7, 7};
        vecs[1] = '{4'd7,  16'h8000, 7680, 4, 11};
        vecs[2] = '{4'd5,  16'h4000, 5376, 2, 9};
        vecs[3] = '{4'd9,  16'hC000, 9984, 6, 13};
        vecs[4] = '{4'd15, 16'h0000, 15360, 15, 15};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; cfg_valid = 1'b0;
        cfg_int = '0; cfg_frac = '0;
        model_reset();
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Constant integer ratio with zero fraction
        cfg_int = 4'd7; cfg_frac = 16'h0000; cfg_valid = 1'b1; en = 1'b1;
        tick_chk();
        chk("r29_ready_after_accept", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        tick_chk();
        chk("r29_ready_after_commit", int'(cfg_ready), 1);
        for (int i = 0; i < 10; i++) begin
            tick_chk();
            chk("r29_out7", int'(out), 7);
            chk("r29_sat0", int'(sat), 0);
        end

        // Offer while disabled: one acceptance, then held off until en
        en = 1'b0; cfg_int = 4'd3; cfg_frac = 16'h1000; cfg_valid = 1'b1;
        tick_chk();
        chk("r31_ready_held", int'(cfg_ready), 0);
        cfg_int = 4'd9; cfg_frac = 16'h2000;
        for (int i = 0; i < 3; i++) begin
            tick_chk();
            chk("r31_second_offer_blocked", int'(cfg_ready), 0);
        end
        cfg_valid = 1'b0; en = 1'b1;
        tick_chk();
        chk("r31_ready_after_en", int'(cfg_ready), 1);
        for (int i = 0; i < 30; i++) tick_chk();

        // Pause for 5 cycles mid-sequence, then resume
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_chk();
            chk("r33_paused_valid", int'(out_valid), 0);
        end
        en = 1'b1;
        for (int i = 0; i < 40; i++) tick_chk();

        // Synchronous clear mid-run keeps the active ratio (3)
        clr = 1'b1;
        tick_chk();
        chk("r34_clr_out", int'(out), 0);
        chk("r34_clr_valid", int'(out_valid), 0);
        clr = 1'b0;
        tick_chk();
        chk("r34_ratio_kept", int'(out), 3);
        for (int i = 0; i < 10; i++) tick_chk();

        // Asynchronous reset with a pending shadow
        en = 1'b0; cfg_int = 4'd11; cfg_frac = 16'h0000; cfg_valid = 1'b1;
        tick_chk();
        cfg_valid = 1'b0;
        chk("r34_pend_set", int'(cfg_ready), 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("r34_rst_out", int'(out), 0);
        chk("r34_rst_sat", int'(sat), 0);
        chk("r34_rst_ready", int'(cfg_ready), 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_chk();
            chk("r34_ratio_lost", int'(out), 0);
        end

        // Table of constant ratios: 1024-cycle mean after warm-up
        for (int v = 0; v < 5; v++) begin
            load_ratio(vecs[v].ci, vecs[v].cf);
            for (int i = 0; i < 64; i++) tick_chk();
            sum = 0; mn = 99; mx = -1; satc = 0;
            for (int i = 0; i < 1024; i++) begin
                tick_chk();
                sum += int'(out);
                if (int'(out) < mn) mn = int'(out);
                if (int'(out) > mx) mx = int'(out);
                satc += int'(sat);
            end
            chk($sformatf("tbl%0d_sum", v), sum, vecs[v].exp_sum);
            chk($sformatf("tbl%0d_nosat", v), satc, 0);
            n_checks++;
            if (!(mn >= vecs[v].lo && mx <= vecs[v].hi)) begin
                n_err++;
                $display("FAIL tbl%0d_range: min %0d max %0d required within %0d..%0d",
                         v, mn, mx, vecs[v].lo, vecs[v].hi);
            end
        end

        // Low-side clamping: ratio 0/0xFFFF
        load_ratio(4'd0, 16'hFFFF);
        for (int i = 0; i < 1000; i++) begin
            tick_chk();
            n_checks++;
            if (int'(out) > 4) begin
                n_err++;
                $display("FAIL r32_out_range: got %0d required 0..4", out);
            end
        end

        // High-side clamping: 15.5 cannot be represented, so sat must occur
        load_ratio(4'd15, 16'h8000);
        satc = 0;
        for (int i = 0; i < 50; i++) begin
            tick_chk();
            satc += int'(sat);
        end
        n_checks++;
        if (satc == 0) begin
            n_err++;
            $display("FAIL hi_clamp_seen: got %0d sat cycles required >0", satc);
        end

        // Full-period mean for 7 + 0.5
        load_ratio(4'd7, 16'h8000);
        for (int i = 0; i < 8; i++) tick_chk();
        sum = 0; mn = 99; mx = -1;
        for (int i = 0; i < 65536; i++) begin
            cycle();
            sum += int'(out);
            if (int'(out) < mn) mn = int'(out);
            if (int'(out) > mx) mx = int'(out);
        end
        chk("r30_sum", sum, 7 * 65536 + 32768);
        n_checks++;
        if (!(mn >= 4 && mx <= 11)) begin
            n_err++;
            $display("FAIL r30_range: min %0d max %0d required within 4..11", mn, mx);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
